mul_hilo_sequencer: RTL and testbench
=====================================

Name: mul_hilo_sequencer

Overview:
- Control stage directly upstream and downstream of the 32x32 combinational array multiplier.
- Accepts an operand pair from the execute stage through a valid/ready handshake and converts signed operands to magnitudes.
- Drives the multiplier inputs from registers and waits a programmable number of cycles for the array to settle (multicycle path).
- Sign-corrects the 64-bit product and holds it in HI/LO result registers for the writeback stage.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- SETTLE_CYCLES, 2, clock edges the registered multiplier inputs are held before mul_p is sampled; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept operands.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with the operands.
- flush  input  1  synchronous abort from the pipeline.
- mul_a  output  WIDTH  registered magnitude driven to the array's first input.
- mul_b  output  WIDTH  registered magnitude driven to the array's second input.
- mul_p  input  2*WIDTH  unsigned product returned by the array.
- out_valid  output  1  HI/LO hold a new result.
- out_ready  input  1  consumer accepts the result.
- hi  output  WIDTH  upper half of the signed-corrected product.
- lo  output  WIDTH  lower half of the signed-corrected product.
- busy  output  1  high in WAIT and DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - mul_a, mul_b, hi, lo, the counter and neg_flag clear to 0.
  - out_valid = 0, busy = 0, in_ready = 1 once rst_n is released.
- State IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1 and flush=0, accept the pair:
    - mul_a <= |op_a| if is_signed, else op_a; mul_b likewise.
    - neg_flag <= is_signed & (op_a[MSB] ^ op_b[MSB]).
    - cnt <= 0; go to WAIT.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned interpretation; no overflow).
- State WAIT:
  - in_ready = 0.
  - If cnt == SETTLE_CYCLES-1: {hi,lo} <= neg_flag ? (~mul_p + 1) : mul_p; out_valid <= 1; go to DONE.
  - Otherwise cnt <= cnt+1.
  - Latency: out_valid is high exactly SETTLE_CYCLES edges after the accept edge.
- State DONE:
  - out_valid = 1; hi/lo stable.
  - On an edge with out_ready=1: out_valid <= 0; go to IDLE.
  - No new accept on the same edge; the next accept is possible at the earliest 1 cycle later.
- mul_a/mul_b change only on an accept edge; they are held through WAIT and DONE so the array inputs stay stable.
- hi/lo change only on the capture edge. They retain their value after the handshake and after a flush until the next capture.
- Negation is a 2*WIDTH-bit two's complement. A zero product with neg_flag set yields 0.
- flush = 1 on any edge:
  - State goes to IDLE; out_valid <= 0; cnt <= 0.
  - hi/lo are not written.
  - flush has priority over accept, capture and out_ready on that edge.
- in_valid with in_ready=0 is ignored; the producer must hold the operands.
- rst_n asserted mid-operation aborts immediately; no partial result is ever visible.

Test Plan:
- Unsigned, SETTLE_CYCLES=2: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, is_signed=0, out_ready=1 → out_valid 2 edges after accept; hi=0xFFFFFFFE, lo=0x00000001; returns to IDLE one edge later.
- Signed mixed: op_a=0xFFFFFFFD (-3), op_b=5, is_signed=1 → mul_a=3, mul_b=5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- Signed corner: op_a=op_b=0x80000000, is_signed=1 → mul_a=mul_b=0x80000000; hi=0x40000000, lo=0x00000000. Also op_a=0, op_b=0xFFFFFFFF signed → hi=lo=0.
- Backpressure: op_a=0x80000000, op_b=2 unsigned, out_ready held 0 for 5 cycles → out_valid stays 1, hi=1, lo=0 stable, in_ready=0, a second in_valid is ignored; out_ready=1 → IDLE, then the second pair is accepted.
- Flush/reset mid-op:
  - Prior result hi=1, lo=0.
  - Accept 7*9, assert flush in WAIT → IDLE with out_valid never high and hi=1, lo=0 retained.
  - Repeat with rst_n pulsed low in WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/mul_hilo_sequencer_if.sv
// Handshake and array-multiplier bus for mul_hilo_sequencer.
// The slave side is the sequencer; the master side is the execute/writeback pipeline plus the array.
interface mul_hilo_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               is_signed;
    logic               flush;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;

    modport slave (
        input  in_valid, op_a, op_b, is_signed, flush, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, hi, lo, busy
    );

    modport master (
        output in_valid, op_a, op_b, is_signed, flush, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, hi, lo, busy
    );
endinterface

// File: rtl/mul_hilo_sequencer.sv
// Sequencer around a combinational array multiplier: takes signed/unsigned operands,
// feeds magnitudes to the array, waits SETTLE_CYCLES edges, then sign-corrects into HI/LO.
module mul_hilo_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_hilo_sequencer_if.slave  bus
);
    localparam int                 MSB      = WIDTH - 1;
    localparam logic [3:0]         CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   ONE_OP   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_PROD = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_in_ready;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod_fixed;

    // The most negative value negates to itself, which read unsigned is its true magnitude.
    assign w_a_neg      = bus.is_signed & bus.op_a[MSB];
    assign w_b_neg      = bus.is_signed & bus.op_b[MSB];
    assign w_mag_a      = w_a_neg ? (~bus.op_a + ONE_OP) : bus.op_a;
    assign w_mag_b      = w_b_neg ? (~bus.op_b + ONE_OP) : bus.op_b;
    assign w_prod_fixed = r_neg ? (~bus.mul_p + ONE_PROD) : bus.mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_neg       <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (bus.flush) begin
            // Abort wins over everything; HI/LO and the array inputs keep their values.
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mul_a    <= w_mag_a;
                        r_mul_b    <= w_mag_b;
                        r_neg      <= w_a_neg ^ w_b_neg;
                        r_cnt      <= 4'd0;
                        r_state    <= ST_WAIT;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        {r_hi, r_lo} <= w_prod_fixed;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.out_valid = r_out_valid;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Self-checking bench for mul_hilo_sequencer; the array multiplier and the expected
// results are modelled here with plain integer arithmetic.
module tb_mul_hilo_sequencer;
    localparam int W  = 32;
    localparam int SC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_hilo_sequencer_if #(.WIDTH(W)) bus ();

    // Behavioural stand-in for the combinational array.
    assign bus.mul_p = {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};

    mul_hilo_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sgn);
        longint   sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] a, input logic sgn);
        if (sgn && $signed(a) < 0) return W'(0) - a;
        return a;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic [2*W-1:0] exp;
        int k;
        exp = ref_prod(a, b, sgn);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL op_ready_before: got %b want 1", bus.in_ready); end
        bus.op_a = a; bus.op_b = b; bus.is_signed = sgn; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.mul_a !== ref_mag(a, sgn)) begin tests_failed++; $display("FAIL op_mul_a: got %h want %h", bus.mul_a, ref_mag(a, sgn)); end
        tests_run++;
        if (bus.mul_b !== ref_mag(b, sgn)) begin tests_failed++; $display("FAIL op_mul_b: got %h want %h", bus.mul_b, ref_mag(b, sgn)); end
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL op_wait_flags: ready=%b busy=%b valid=%b want 0 1 0", bus.in_ready, bus.busy, bus.out_valid);
        end
        k = 0;
        while (bus.out_valid !== 1'b1 && k <= 20) begin @(posedge clk); #1; k++; end
        tests_run++;
        if (k != SC) begin tests_failed++; $display("FAIL op_latency: got %0d want %0d", k, SC); end
        tests_run++;
        if ({bus.hi, bus.lo} !== exp) begin tests_failed++; $display("FAIL op_result: got %h_%h want %h", bus.hi, bus.lo, exp); end
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.hi, bus.lo} !== exp) begin
            tests_failed++; $display("FAIL op_release: valid=%b ready=%b hilo=%h_%h want 0 1 %h", bus.out_valid, bus.in_ready, bus.hi, bus.lo, exp);
        end
        $display("[TB] op a=%h b=%h signed=%0d -> hi=%h lo=%h", a, b, sgn, bus.hi, bus.lo);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        tests_run++;
        if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.hi !== '0 || bus.lo !== '0) begin
            tests_failed++; $display("FAIL reset_regs: a=%h b=%h hi=%h lo=%h want all 0", bus.mul_a, bus.mul_b, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        $display("[TB] reset released");
    endtask

    task automatic test_directed();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tests_run++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin tests_failed++; $display("FAIL dir_unsigned_max: got %h_%h", bus.hi, bus.lo); end
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        tests_run++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin tests_failed++; $display("FAIL dir_neg15: got %h_%h", bus.hi, bus.lo); end
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        tests_run++;
        if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000) begin tests_failed++; $display("FAIL dir_minint_sq: got %h_%h", bus.hi, bus.lo); end
        run_op(32'h0, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if ({bus.hi, bus.lo} !== 64'h0) begin tests_failed++; $display("FAIL dir_neg_zero: got %h_%h", bus.hi, bus.lo); end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return W'($urandom);
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            default: return W'($urandom_range(0, 100));
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_backpressure();
        int k;
        bus.op_a = 32'h8000_0000; bus.op_b = 32'd2; bus.is_signed = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.op_a = 32'd3; bus.op_b = 32'd4;
        k = 0;
        while (bus.out_valid !== 1'b1 && k <= 20) begin @(posedge clk); #1; k++; end
        tests_run++;
        if (k != SC) begin tests_failed++; $display("FAIL bp_latency: got %0d want %0d", k, SC); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.hi !== 32'd1 || bus.lo !== 32'd0 || bus.mul_a !== 32'h8000_0000) begin
                tests_failed++;
                $display("FAIL bp_hold: valid=%b ready=%b hi=%h lo=%h mul_a=%h want 1 0 1 0 80000000", bus.out_valid, bus.in_ready, bus.hi, bus.lo, bus.mul_a);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mul_a !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL bp_release: valid=%b ready=%b mul_a=%h want 0 1 80000000", bus.out_valid, bus.in_ready, bus.mul_a);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.mul_a !== 32'd3 || bus.mul_b !== 32'd4 || bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL bp_second_accept: a=%h b=%h busy=%b want 3 4 1", bus.mul_a, bus.mul_b, bus.busy);
        end
        k = 0;
        while (bus.out_valid !== 1'b1 && k <= 20) begin @(posedge clk); #1; k++; end
        tests_run++;
        if ({bus.hi, bus.lo} !== ref_prod(32'd3, 32'd4, 1'b0) || k != SC) begin
            tests_failed++; $display("FAIL bp_second_result: got %h_%h lat %0d want %h lat %0d", bus.hi, bus.lo, k, ref_prod(32'd3, 32'd4, 1'b0), SC);
        end
        @(posedge clk); #1;
        $display("[TB] backpressure sequence done");
    endtask

    task automatic test_flush();
        int seen;
        run_op(32'h8000_0000, 32'd2, 1'b0);
        bus.op_a = 32'd7; bus.op_b = 32'd9; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b1;
        tests_run++;
        if (bus.mul_a !== 32'd7 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL flush_accept: a=%h busy=%b want 7 1", bus.mul_a, bus.busy); end
        @(posedge clk); #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            tests_failed++; $display("FAIL flush_idle: busy=%b ready=%b valid=%b hi=%h lo=%h want 0 1 0 1 0", bus.busy, bus.in_ready, bus.out_valid, bus.hi, bus.lo);
        end
        // Flush held with a valid pair present must block the accept.
        bus.op_a = 32'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.mul_a !== 32'd7) begin tests_failed++; $display("FAIL flush_blocks_accept: busy=%b a=%h want 0 7", bus.busy, bus.mul_a); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
        tests_run++;
        if (seen != 0 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            tests_failed++; $display("FAIL flush_no_result: valid_seen=%0d hi=%h lo=%h want 0 1 0", seen, bus.hi, bus.lo);
        end
        $display("[TB] flush sequence done");
    endtask

    task automatic test_reset_midop();
        bus.op_a = 32'd11; bus.op_b = 32'd13; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.hi !== '0 || bus.lo !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: a=%h b=%h hi=%h lo=%h valid=%b busy=%b want all 0", bus.mul_a, bus.mul_b, bus.hi, bus.lo, bus.out_valid, bus.busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.hi !== '0) begin
            tests_failed++; $display("FAIL rst_recover: ready=%b valid=%b hi=%h want 1 0 0", bus.in_ready, bus.out_valid, bus.hi);
        end
        $display("[TB] reset mid-op done");
        run_op(32'hFFFF_FFFA, 32'd7, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.is_signed = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
